conv_window_gen: RTL and testbench
==================================

Name: conv_window_gen

Overview:
Downstream consumer of the multi-channel activation FIFO in the VGG16 datapath. Pops one pixel per cycle (all channels packed) in raster order, buffers the two previous image rows, and emits every 3x3 sliding window (stride 1, no padding) to the convolution engine with valid/ready flow control. Each frame is started by a `start` pulse, and completion is reported with `frame_done`.

Parameters:
- DATA_WIDTH, 32: bits per channel sample.
- CHANNEL, 3: channels packed per pixel; pixel width PW = DATA_WIDTH*CHANNEL.
- IMG_WIDTH, 224: pixels per row (>=3).
- IMG_HEIGHT, 224: rows per frame (>=3).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse begins a frame; ignored while busy=1.
- fifo_empty  in  1  upstream FIFO empty flag.
- fifo_data  in  PW  upstream pixel; valid in the same cycle fifo_rd_req=1.
- fifo_rd_req  out  1  pop request to upstream FIFO (combinational).
- win_ready  in  1  convolution engine accepts the window.
- win_valid  out  1  win_data holds a valid window.
- win_data  out  9*PW  window; slot k=r*3+c at [k*PW +: PW], r=0 top row, c=0 leftmost column.
- busy  out  1  frame in progress (state != IDLE).
- frame_done  out  1  one-cycle pulse when the last window of a frame has been accepted.

Behaviour:
- Reset values: fifo_rd_req=0, win_valid=0, win_data=0, busy=0, frame_done=0, x=y=0, state=IDLE. Line-buffer RAM contents are not reset and are don't-care.
- State IDLE: on start=1, go to RUN and clear the counters x and y.
- State RUN: fifo_rd_req = !fifo_empty && (!win_valid || win_ready). A cycle with fifo_rd_req=1 is an "accept" of pixel P at column x, row y.
- On accept, column memories: lb1[x] <= lb0[x]; lb0[x] <= P. lb0 holds row y-1 and lb1 holds row y-2.
- On accept, window shift register: columns c0 <= c1, c1 <= c2; new c2 = {top=lb1[x], mid=lb0[x], bottom=P}. Values are read before the write in the same cycle.
- Counters: x increments and wraps IMG_WIDTH-1 -> 0; y increments when x wraps.
- Output register: if the accept has x>=2 and y>=2, then next cycle win_valid=1 and win_data holds rows y-2..y, columns x-2..x. Latency is 1 cycle from accept.
- Handshake: a window transfers when win_valid && win_ready. win_valid falls after transfer unless a new window is loaded in the same cycle.
- Stall: while win_valid && !win_ready, win_data is held stable and fifo_rd_req=0.
- Row boundary: windows never straddle rows. Accepts with x<2 or y<2 produce no window.
- Window count: exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.
- End of frame: accepting pixel (IMG_WIDTH-1, IMG_HEIGHT-1) moves the state to DRAIN; no further pops.
- State DRAIN: when the final window transfers, pulse frame_done for 1 cycle and go to IDLE. busy falls in the same cycle frame_done is high.
- fifo_empty=1 in RUN: no pop and no counter change. Gaps of any length are legal.
- rst asserted mid-frame: return immediately to reset values. The partial frame is discarded; the next start begins a fresh frame at (0,0).
- start while busy: ignored, no effect on counters or data.
- The block never pops while fifo_empty=1, and never pops outside RUN.

Test Plan:
Test config: IMG_WIDTH=4, IMG_HEIGHT=4, DATA_WIDTH=8, CHANNEL=1. Source pixel value = 4*y+x.
1. Basic frame: FIFO preloaded, win_ready=1, start pulse -> 16 pops, 4 windows.
   - First window = slots 0..8 {0,1,2,4,5,6,8,9,10}, win_valid 1 cycle after pop of pixel 10.
   - Last window = {5,6,7,9,10,11,13,14,15}.
   - frame_done pulses once, busy=0 afterwards.
2. Backpressure: win_ready=0 for 5 cycles while first window valid -> win_data stays {0,1,2,4,5,6,8,9,10}, fifo_rd_req=0 throughout; after ready, remaining windows correct and in order.
3. Starved source: fifo_empty toggles every other cycle -> fifo_rd_req never high while empty; same 4 windows as scenario 1; no duplicated or skipped pixels.
4. Reset mid-frame: assert rst after 9 pops -> all outputs 0 and busy=0; new start with a fresh stream gives first window {0,1,2,4,5,6,8,9,10}.
5. start ignored while busy: pulse start at pop 6 -> window sequence and frame_done timing identical to scenario 1.
6. Back-to-back frames: second start the cycle after frame_done, second frame values offset by +100 -> first window {100,101,102,104,105,106,108,109,110}; no contamination from frame 1 line buffers.

Source files
------------

// File: rtl/conv_window_gen_if.sv
// Pixel-stream and window handshake bundle for conv_window_gen.
// The controlling side (FIFO/engine) uses master; the window generator uses slave.
interface conv_window_gen_if #(
  parameter int PW = 96
);
  logic            start;
  logic            fifo_empty;
  logic [PW-1:0]   fifo_data;
  logic            fifo_rd_req;
  logic            win_ready;
  logic            win_valid;
  logic [9*PW-1:0] win_data;
  logic            busy;
  logic            frame_done;

  modport master (
    output start, fifo_empty, fifo_data, win_ready,
    input  fifo_rd_req, win_valid, win_data, busy, frame_done
  );

  modport slave (
    input  start, fifo_empty, fifo_data, win_ready,
    output fifo_rd_req, win_valid, win_data, busy, frame_done
  );
endinterface

// File: rtl/conv_window_gen.sv
// 3x3 sliding-window generator: pops raster-order pixels, keeps two row
// buffers and emits every stride-1 window with valid/ready flow control.
//
// state | meaning
// IDLE  | waiting for start, no pops
// RUN   | popping pixels and producing windows
// DRAIN | all pixels popped, waiting for the last window to be taken
module conv_window_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int CHANNEL    = 3,
  parameter int IMG_WIDTH  = 224,
  parameter int IMG_HEIGHT = 224
) (
  input logic             clk,
  input logic             rst,
  conv_window_gen_if.slave bus
);
  localparam int PW = DATA_WIDTH * CHANNEL;
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [3*PW-1:0] col_xm2_q, col_xm2_d;
  logic [3*PW-1:0] col_xm1_q, col_xm1_d;
  logic [9*PW-1:0] win_data_q, win_data_d;
  logic            win_valid_q, win_valid_d;
  logic            frame_done_q, frame_done_d;

  logic [PW-1:0]   lb0_mem [IMG_WIDTH];
  logic [PW-1:0]   lb1_mem [IMG_WIDTH];

  logic            accept;
  logic            win_xfer;
  logic            x_last;
  logic            y_last;
  logic [3*PW-1:0] new_col;

  assign win_xfer = win_valid_q && bus.win_ready;
  assign accept   = (state_q == RUN) && !bus.fifo_empty && (!win_valid_q || bus.win_ready);
  assign x_last   = (x_q == XW'(IMG_WIDTH - 1));
  assign y_last   = (y_q == YW'(IMG_HEIGHT - 1));
  // Column packed with the top row (two rows up) in the lowest slot.
  assign new_col  = {bus.fifo_data, lb0_mem[x_q], lb1_mem[x_q]};

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    col_xm2_d    = col_xm2_q;
    col_xm1_d    = col_xm1_q;
    win_data_d   = win_data_q;
    win_valid_d  = win_valid_q && !bus.win_ready;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          x_d     = '0;
          y_d     = '0;
        end
      end
      RUN: begin
        if (accept) begin
          col_xm2_d = col_xm1_q;
          col_xm1_d = new_col;
          if (x_q >= XW'(2) && y_q >= YW'(2)) begin
            win_valid_d = 1'b1;
            for (int r = 0; r < 3; r++) begin
              win_data_d[(3*r)*PW   +: PW] = col_xm2_q[r*PW +: PW];
              win_data_d[(3*r+1)*PW +: PW] = col_xm1_q[r*PW +: PW];
              win_data_d[(3*r+2)*PW +: PW] = new_col[r*PW +: PW];
            end
          end
          if (x_last) begin
            x_d = '0;
            if (y_last) begin
              y_d     = '0;
              state_d = DRAIN;
            end else begin
              y_d = y_q + YW'(1);
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      DRAIN: begin
        if (win_xfer) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      col_xm2_q    <= '0;
      col_xm1_q    <= '0;
      win_data_q   <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      col_xm2_q    <= col_xm2_d;
      col_xm1_q    <= col_xm1_d;
      win_data_q   <= win_data_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Row buffers carry no reset; rows 0 and 1 never produce windows.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_mem[x_q] <= lb0_mem[x_q];
      lb0_mem[x_q] <= bus.fifo_data;
    end
  end

  assign bus.fifo_rd_req = accept;
  assign bus.win_valid   = win_valid_q;
  assign bus.win_data    = win_data_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.frame_done  = frame_done_q;
endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen on a 4x4, 8-bit, single-channel image.
module tb_conv_window_gen;
  localparam int DW = 8;
  localparam int CH = 1;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = DW * CH;
  localparam int N  = W * H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_window_gen_if #(.PW(PW)) bus();

  conv_window_gen #(
    .DATA_WIDTH(DW), .CHANNEL(CH), .IMG_WIDTH(W), .IMG_HEIGHT(H)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int              scen;
    int              kind;   // 0: captured window, 1: start-to-frame_done cycles
    int              idx;
    logic [9*PW-1:0] exp;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit              m_active;
  bit              m_done;
  int              m_pops;
  int              m_pend;
  logic [PW-1:0]   src[$];
  logic [9*PW-1:0] sb[$];
  logic [9*PW-1:0] got[$];

  int gap_mode;
  int rdy_mode;
  int stall_cnt;
  int cyc = 0;
  bit saw_done;

  logic [9*PW-1:0] cap [7][4];
  int              lat_rec [7];
  vec_t            tbl [14];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [9*PW-1:0] pk9(input int a0, input int a1, input int a2,
                                          input int a3, input int a4, input int a5,
                                          input int a6, input int a7, input int a8);
    logic [9*PW-1:0] r;
    r = {a8[7:0], a7[7:0], a6[7:0], a5[7:0], a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
    return r;
  endfunction

  // Fills the source FIFO in raster order and lists every expected window.
  task automatic prep_frame(input int base, input bit rnd);
    logic [PW-1:0]   pix [H][W];
    logic [9*PW-1:0] w;
    int              v;
    src.delete();
    sb.delete();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        v = rnd ? int'($urandom_range(0, 255)) : base + 4*y + x;
        pix[y][x] = v[PW-1:0];
        src.push_back(pix[y][x]);
      end
    for (int y = 2; y < H; y++)
      for (int x = 2; x < W; x++) begin
        w = '0;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            w[(r*3+c)*PW +: PW] = pix[y-2+r][x-2+c];
        sb.push_back(w);
      end
  endtask

  task automatic tick(input bit start_in);
    bit gap, emp, rdy, exp_pop, xfer, old_active;
    int px, py;
    @(negedge clk);
    case (gap_mode)
      1:       gap = (cyc % 2) == 1;
      2:       gap = ($urandom_range(0, 2) == 0);
      default: gap = 1'b0;
    endcase
    emp = gap || (src.size() == 0);
    case (rdy_mode)
      1: begin
        if (m_pend > 0 && stall_cnt < 5) begin
          rdy = 1'b0;
          stall_cnt++;
        end else rdy = 1'b1;
      end
      2:       rdy = ($urandom_range(0, 1) == 1);
      default: rdy = 1'b1;
    endcase
    bus.fifo_empty = emp;
    bus.fifo_data  = (src.size() > 0) ? src[0] : '0;
    bus.win_ready  = rdy;
    bus.start      = start_in;
    #1;
    exp_pop = m_active && (m_pops < N) && !emp && (m_pend == 0 || rdy);
    xfer    = (m_pend > 0) && rdy;
    chk("busy", bus.busy, m_active);
    chk("frame_done", bus.frame_done, m_done);
    chk("win_valid", bus.win_valid, m_pend > 0);
    chk("fifo_rd_req", bus.fifo_rd_req, exp_pop);
    saw_done = m_done;
    if (m_pend > 0 && sb.size() > 0) chk("win_data", bus.win_data, sb[0]);
    if (xfer) begin
      got.push_back(bus.win_data);
      if (sb.size() > 0) sb.delete(0);
    end
    old_active = m_active;
    m_done = 1'b0;
    if (exp_pop) begin
      px = m_pops % W;
      py = m_pops / W;
      if (px >= 2 && py >= 2) m_pend++;
      src.delete(0);
      m_pops++;
    end
    if (xfer) begin
      m_pend--;
      if (m_pops == N && m_pend == 0) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end
    if (start_in && !old_active) begin
      m_active = 1'b1;
      m_pops   = 0;
      m_pend   = 0;
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.fifo_empty = 1'b0;
    bus.fifo_data  = '0;
    bus.win_ready  = 1'b1;
    bus.start      = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_win_valid", bus.win_valid, 0);
    chk("rst_win_data", bus.win_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_fifo_rd_req", bus.fifo_rd_req, 0);
    m_active = 1'b0;
    m_done   = 1'b0;
    m_pops   = 0;
    m_pend   = 0;
    src.delete();
    sb.delete();
    got.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_frame(input int scen, input int base, input bit rnd, input int gm,
                           input int rm, input int extra_start_pop, input int abort_pops);
    int lat;
    bit sent, fin, s;
    gap_mode  = gm;
    rdy_mode  = rm;
    stall_cnt = 0;
    got.delete();
    prep_frame(base, rnd);
    tick(1'b1);
    lat  = 0;
    sent = 1'b0;
    fin  = 1'b0;
    for (int i = 0; i < 500 && !fin; i++) begin
      s = 1'b0;
      if (extra_start_pop >= 0 && !sent && m_pops == extra_start_pop) begin
        s    = 1'b1;
        sent = 1'b1;
      end
      tick(s);
      lat++;
      if (abort_pops > 0 && m_pops >= abort_pops) begin
        do_reset();
        return;
      end
      if (saw_done) fin = 1'b1;
    end
    if (!fin) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame_timeout scen %0d: frame_done not seen, required within 500 cycles", scen);
    end
    if (scen >= 0) begin
      lat_rec[scen] = lat;
      for (int k = 0; k < got.size() && k < 4; k++) cap[scen][k] = got[k];
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required under 500000 time units");
    $fatal(1);
  end

  initial begin
    logic [9*PW-1:0] wa, wb, w1, w2, wc, wd;
    wa = pk9(0, 1, 2, 4, 5, 6, 8, 9, 10);
    w1 = pk9(1, 2, 3, 5, 6, 7, 9, 10, 11);
    w2 = pk9(4, 5, 6, 8, 9, 10, 12, 13, 14);
    wb = pk9(5, 6, 7, 9, 10, 11, 13, 14, 15);
    wc = pk9(100, 101, 102, 104, 105, 106, 108, 109, 110);
    wd = pk9(105, 106, 107, 109, 110, 111, 113, 114, 115);
    tbl[0]  = '{1, 0, 0, wa};
    tbl[1]  = '{1, 0, 1, w1};
    tbl[2]  = '{1, 0, 2, w2};
    tbl[3]  = '{1, 0, 3, wb};
    tbl[4]  = '{1, 1, 0, 72'd18};
    tbl[5]  = '{2, 0, 0, wa};
    tbl[6]  = '{2, 0, 3, wb};
    tbl[7]  = '{3, 0, 0, wa};
    tbl[8]  = '{3, 0, 3, wb};
    tbl[9]  = '{4, 0, 0, wa};
    tbl[10] = '{5, 0, 0, wa};
    tbl[11] = '{5, 1, 0, 72'd18};
    tbl[12] = '{6, 0, 0, wc};
    tbl[13] = '{6, 0, 3, wd};
    for (int s = 0; s < 7; s++) begin
      lat_rec[s] = -1;
      for (int k = 0; k < 4; k++) cap[s][k] = '0;
    end

    bus.start      = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_data  = '0;
    bus.win_ready  = 1'b1;
    gap_mode = 0;
    rdy_mode = 0;
    do_reset();

    run_frame(1, 0, 1'b0, 0, 0, -1, 0);
    run_frame(2, 0, 1'b0, 0, 1, -1, 0);
    run_frame(3, 0, 1'b0, 1, 0, -1, 0);
    run_frame(-1, 0, 1'b0, 0, 0, -1, 9);
    run_frame(4, 0, 1'b0, 0, 0, -1, 0);
    run_frame(5, 0, 1'b0, 0, 0, 6, 0);
    run_frame(-1, 0, 1'b0, 0, 0, -1, 0);
    run_frame(6, 100, 1'b0, 0, 0, -1, 0);
    for (int f = 0; f < 4; f++)
      run_frame(-1, 0, 1'b1, 2, 2, int'($urandom_range(0, 15)), 0);

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].kind == 0)
        chk($sformatf("tbl%0d_s%0d_win%0d", i, tbl[i].scen, tbl[i].idx),
            cap[tbl[i].scen][tbl[i].idx], tbl[i].exp);
      else
        chk($sformatf("tbl%0d_s%0d_done_latency", i, tbl[i].scen),
            lat_rec[tbl[i].scen], tbl[i].exp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
